// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low glyphs (bit 6 = a .. bit 0 = g),
// the readback tracker state type and the forward code-to-glyph encoder.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0001100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HOLD  = 2'd2
    } rb_state_t;

    typedef struct packed {
        logic       legal;
        logic       blank;
        logic [3:0] code;
    } seg_dec_t;

    function automatic logic [6:0] code_to_seg(input logic [3:0] code);
        case (code)
            4'h0:    return SEG_0;
            4'h1:    return SEG_1;
            4'h2:    return SEG_2;
            4'h3:    return SEG_3;
            4'h4:    return SEG_4;
            4'h5:    return SEG_5;
            4'h6:    return SEG_6;
            4'h7:    return SEG_7;
            4'h8:    return SEG_8;
            4'h9:    return SEG_9;
            4'hA:    return SEG_A;
            4'hB:    return SEG_B;
            4'hC:    return SEG_C;
            4'hD:    return SEG_D;
            4'hE:    return SEG_E;
            default: return SEG_F;
        endcase
    endfunction

endpackage

// File: rtl/seg7_to_code.sv
// Inverse glyph decoder: active-low segment pattern to {legal, blank, code}.
module seg7_to_code
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output seg_dec_t   dec_o
);

    // Reusing the forward encoder keeps both directions on one glyph table.
    always_comb begin
        dec_o       = '0;
        dec_o.blank = (seg_i == SEG_BLANK);
        for (int c = 0; c < 16; c++) begin
            if (seg_i == code_to_seg(4'(c))) begin
                dec_o.legal = 1'b1;
                dec_o.code  = 4'(c);
            end
        end
    end

endmodule

// File: rtl/seg_readback.sv
// Seven-segment bus readback: settles each multiplexed digit and decodes it back to a code.
// Define SEG_READBACK_ERR_EN to build the illegal-pattern path and sticky err_illegal flag.
module seg_readback
    import seg7_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          seg,
    input  logic [DIGITS-1:0]   an,
    input  logic                clr,
    output logic [4*DIGITS-1:0] digit_bcd,
    output logic [DIGITS-1:0]   digit_valid,
    output logic                frame_done,
    output logic                err_illegal,
    output rb_state_t           dbg_state
);

    localparam int             CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic [6:0]          seg_q;
    logic [DIGITS-1:0]   an_q;
    rb_state_t           state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [DIGITS-1:0]   valid_q, valid_d;
    logic [DIGITS-1:0]   seen_q, seen_d;
    logic                frame_q, frame_d;
    logic                err_q, err_d;
    logic                change;
    logic                capture;
    seg_dec_t            dec;

    seg7_to_code u_dec (
        .seg_i (seg_q),
        .dec_o (dec)
    );

    // The incoming sample is compared with the one already registered, so the
    // counter holds the number of identical registered samples.
    assign change = ({an, seg} != {an_q, seg_q});

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            seg_q   <= SEG_BLANK;
            an_q    <= '1;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            seg_q   <= seg;
            an_q    <= an;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (change) begin
            cnt_d   = CNT_W'(1);
            state_d = $onehot(~an) ? TRACK : IDLE;
        end else begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            if (state_q == TRACK && cnt_q == CNT_MAX) state_d = HOLD;
        end
    end

    always_comb begin
        capture   = (state_q == TRACK) && (cnt_q == CNT_MAX);
        dbg_state = state_q;
    end

    always_comb begin
        bcd_d   = bcd_q;
        valid_d = valid_q;
        seen_d  = seen_q;
        err_d   = err_q;
        frame_d = 1'b0;
        if (capture) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (!an_q[i]) begin
                    seen_d[i] = 1'b1;
                    if (dec.legal) begin
                        bcd_d[4*i +: 4] = dec.code;
                        valid_d[i]      = 1'b1;
                    end else if (dec.blank) begin
                        bcd_d[4*i +: 4] = 4'h0;
                        valid_d[i]      = 1'b0;
                    end else begin
`ifdef SEG_READBACK_ERR_EN
                        valid_d[i] = 1'b0;
                        err_d      = 1'b1;
`else
                        bcd_d[4*i +: 4] = 4'h0;
                        valid_d[i]      = 1'b0;
`endif
                    end
                end
            end
            // The completing capture belongs to this frame only.
            if (&seen_d) begin
                frame_d = 1'b1;
                seen_d  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            bcd_q   <= '0;
            valid_q <= '0;
            seen_q  <= '0;
            frame_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            bcd_q   <= bcd_d;
            valid_q <= valid_d;
            seen_q  <= seen_d;
            frame_q <= frame_d;
            err_q   <= err_d;
        end
    end

    assign digit_bcd   = bcd_q;
    assign digit_valid = valid_q;
    assign frame_done  = frame_q;
    assign err_illegal = err_q;

endmodule
